mc_ctrl_fsm: RTL and testbench

//   Multi-cycle control FSM for the MIPS datapath (add, sub, ori, lui, lw, sw, beq, jal, jr).

---
 rtl/mc_ctrl_fsm.sv | 224 ++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control sequencer (FETCH/DECODE/EXE/BR/MEM/WB).
// Gates datapath write-enables, runs the IM/DM req/ready handshakes and counts retired instructions.
module mc_ctrl_fsm #(
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir,
  input  logic             alu_zero,
  input  logic             im_ready,
  input  logic             dm_ready,
  output logic             im_req,
  output logic             dm_req,
  output logic             dm_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             ab_we,
  output logic             alu_out_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic [1:0]       rf_wr_sel,
  output logic [1:0]       rf_wd_sel,
  output logic             illegal,
  output logic [RET_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_BR     = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    I_ADD = 4'd0, I_SUB = 4'd1, I_ORI = 4'd2, I_LUI = 4'd3, I_LW  = 4'd4,
    I_SW  = 4'd5, I_BEQ = 4'd6, I_JAL = 4'd7, I_JR  = 4'd8, I_BAD = 4'd9
  } kind_t;

  localparam logic [RET_W-1:0] RET_ONE = {{(RET_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           next_s;
  logic [RET_W-1:0] retired_r;
  logic             retire_s;
  kind_t            kind_s;
  logic             ir_unused_s;

  logic       im_req_s, dm_req_s, dm_we_s, ir_we_s, pc_we_s, ab_we_s;
  logic       alu_out_we_s, mdr_we_s, rf_we_s, illegal_s;
  logic [1:0] npc_sel_s, rf_wr_sel_s, rf_wd_sel_s;

  // Register and shift-amount fields are decoded by the datapath, not here.
  assign ir_unused_s = ^ir[25:6];

  // Classify the instruction held in IR.
  always_comb begin
    case (ir[31:26])
      6'b000000: begin
        case (ir[5:0])
          6'b100000: kind_s = I_ADD;
          6'b100010: kind_s = I_SUB;
          6'b001000: kind_s = I_JR;
          default:   kind_s = I_BAD;
        endcase
      end
      6'b001101: kind_s = I_ORI;
      6'b001111: kind_s = I_LUI;
      6'b100011: kind_s = I_LW;
      6'b101011: kind_s = I_SW;
      6'b000100: kind_s = I_BEQ;
      6'b000011: kind_s = I_JAL;
      default:   kind_s = I_BAD;
    endcase
  end

  // Next-state, retire and control decode from state, IR and ready inputs.
  always_comb begin
    next_s       = S_FETCH;
    retire_s     = 1'b0;
    im_req_s     = 1'b0;
    dm_req_s     = 1'b0;
    dm_we_s      = 1'b0;
    ir_we_s      = 1'b0;
    pc_we_s      = 1'b0;
    npc_sel_s    = 2'd0;
    ab_we_s      = 1'b0;
    alu_out_we_s = 1'b0;
    mdr_we_s     = 1'b0;
    rf_we_s      = 1'b0;
    rf_wr_sel_s  = 2'd0;
    rf_wd_sel_s  = 2'd0;
    illegal_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        im_req_s = 1'b1;
        if (im_ready) begin
          ir_we_s = 1'b1;
          pc_we_s = 1'b1;
          next_s  = S_DECODE;
        end else begin
          next_s  = S_FETCH;
        end
      end
      S_DECODE: begin
        ab_we_s = 1'b1;
        case (kind_s)
          I_JAL: begin
            rf_we_s     = 1'b1;
            rf_wr_sel_s = 2'd2;
            rf_wd_sel_s = 2'd2;
            pc_we_s     = 1'b1;
            npc_sel_s   = 2'd2;
            retire_s    = 1'b1;
          end
          I_JR: begin
            pc_we_s   = 1'b1;
            npc_sel_s = 2'd3;
            retire_s  = 1'b1;
          end
          I_BEQ:                                      next_s = S_BR;
          I_ADD, I_SUB, I_ORI, I_LUI, I_LW, I_SW:     next_s = S_EXE;
          default: begin
            illegal_s = 1'b1;
            retire_s  = 1'b1;
          end
        endcase
      end
      S_BR: begin
        pc_we_s   = alu_zero;
        npc_sel_s = 2'd1;
        retire_s  = 1'b1;
      end
      S_EXE: begin
        alu_out_we_s = 1'b1;
        case (kind_s)
          I_LW, I_SW:                 next_s = S_MEM;
          I_ADD, I_SUB, I_ORI, I_LUI: next_s = S_WB;
          default:                    next_s = S_FETCH;
        endcase
      end
      S_MEM: begin
        dm_req_s = 1'b1;
        dm_we_s  = (kind_s == I_SW);
        if (!dm_ready) begin
          next_s = S_MEM;
        end else if (kind_s == I_LW) begin
          mdr_we_s = 1'b1;
          next_s   = S_WB;
        end else begin
          retire_s = 1'b1;
        end
      end
      S_WB: begin
        rf_we_s  = 1'b1;
        retire_s = 1'b1;
        if (kind_s == I_ADD || kind_s == I_SUB) begin
          rf_wr_sel_s = 2'd1;
        end else begin
          rf_wr_sel_s = 2'd0;
        end
        if (kind_s == I_LW) begin
          rf_wd_sel_s = 2'd1;
        end else begin
          rf_wd_sel_s = 2'd0;
        end
      end
      default: next_s = S_FETCH;
    endcase
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_FETCH;
      retired_r <= '0;
    end else begin
      state_r <= next_s;
      if (retire_s) begin
        retired_r <= retired_r + RET_ONE;
      end
    end
  end

  // Hold every control output low while reset is asserted, so an abort cancels any access at once.
  always_comb begin
    if (reset) begin
      im_req     = 1'b0;
      dm_req     = 1'b0;
      dm_we      = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      npc_sel    = 2'd0;
      ab_we      = 1'b0;
      alu_out_we = 1'b0;
      mdr_we     = 1'b0;
      rf_we      = 1'b0;
      rf_wr_sel  = 2'd0;
      rf_wd_sel  = 2'd0;
      illegal    = 1'b0;
    end else begin
      im_req     = im_req_s;
      dm_req     = dm_req_s;
      dm_we      = dm_we_s;
      ir_we      = ir_we_s;
      pc_we      = pc_we_s;
      npc_sel    = npc_sel_s;
      ab_we      = ab_we_s;
      alu_out_we = alu_out_we_s;
      mdr_we     = mdr_we_s;
      rf_we      = rf_we_s;
      rf_wr_sel  = rf_wr_sel_s;
      rf_wd_sel  = rf_wd_sel_s;
      illegal    = illegal_s;
    end
  end

  assign state   = state_r;
  assign retired = retired_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed scenarios then random instruction streams, each instruction
// expanded into its expected per-cycle control trace; a 3-bit-counter instance checks wrap.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic        alu_zero, im_ready, dm_ready;

  logic        im_req, dm_req, dm_we, ir_we, pc_we, ab_we, alu_out_we, mdr_we, rf_we, illegal;
  logic [1:0]  npc_sel, rf_wr_sel, rf_wd_sel;
  logic [31:0] retired;
  logic [2:0]  state;

  logic        w_im_req, w_dm_req, w_dm_we, w_ir_we, w_pc_we, w_ab_we, w_alu_out_we, w_mdr_we, w_rf_we, w_illegal;
  logic [1:0]  w_npc_sel, w_rf_wr_sel, w_rf_wd_sel;
  logic [2:0]  w_retired;
  logic [2:0]  w_state;

  logic [15:0] ctl, w_ctl;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_ret = 32'd0;

  localparam int K_ADD = 0, K_SUB = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5,
                 K_BEQ = 6, K_JAL = 7, K_JR = 8, K_BADOP = 9, K_BADFN = 10;

  localparam logic [15:0] C_IMREQ = 16'h8000, C_DMREQ = 16'h4000, C_DMWE = 16'h2000,
                          C_IRWE  = 16'h1000, C_PCWE  = 16'h0800, C_AB   = 16'h0100,
                          C_ALU   = 16'h0080, C_MDR   = 16'h0040, C_RFWE = 16'h0020,
                          C_ILL   = 16'h0001, C_NONE  = 16'h0000;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .ir(ir), .alu_zero(alu_zero), .im_ready(im_ready), .dm_ready(dm_ready),
    .im_req(im_req), .dm_req(dm_req), .dm_we(dm_we), .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel),
    .ab_we(ab_we), .alu_out_we(alu_out_we), .mdr_we(mdr_we), .rf_we(rf_we), .rf_wr_sel(rf_wr_sel),
    .rf_wd_sel(rf_wd_sel), .illegal(illegal), .retired(retired), .state(state)
  );

  mc_ctrl_fsm #(.RET_W(3)) dut_w (
    .clk(clk), .reset(reset), .ir(ir), .alu_zero(alu_zero), .im_ready(im_ready), .dm_ready(dm_ready),
    .im_req(w_im_req), .dm_req(w_dm_req), .dm_we(w_dm_we), .ir_we(w_ir_we), .pc_we(w_pc_we),
    .npc_sel(w_npc_sel), .ab_we(w_ab_we), .alu_out_we(w_alu_out_we), .mdr_we(w_mdr_we), .rf_we(w_rf_we),
    .rf_wr_sel(w_rf_wr_sel), .rf_wd_sel(w_rf_wd_sel), .illegal(w_illegal), .retired(w_retired),
    .state(w_state)
  );

  assign ctl   = {im_req, dm_req, dm_we, ir_we, pc_we, npc_sel, ab_we, alu_out_we, mdr_we,
                  rf_we, rf_wr_sel, rf_wd_sel, illegal};
  assign w_ctl = {w_im_req, w_dm_req, w_dm_we, w_ir_we, w_pc_we, w_npc_sel, w_ab_we, w_alu_out_we,
                  w_mdr_we, w_rf_we, w_rf_wr_sel, w_rf_wd_sel, w_illegal};

  always #5 clk = ~clk;

  function automatic logic [15:0] npc(input logic [1:0] v);
    return {5'b0, v, 9'b0};
  endfunction
  function automatic logic [15:0] wr(input logic [1:0] v);
    return {11'b0, v, 3'b0};
  endfunction
  function automatic logic [15:0] wd(input logic [1:0] v);
    return {13'b0, v, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic step(input string tag, input logic [2:0] st, input logic [15:0] c);
    #2;
    check({tag, ".ctl"},       {16'b0, ctl},     {16'b0, c});
    check({tag, ".state"},     {29'b0, state},   {29'b0, st});
    check({tag, ".retired"},   retired,          exp_ret);
    check({tag, ".w_ctl"},     {16'b0, w_ctl},   {16'b0, c});
    check({tag, ".w_state"},   {29'b0, w_state}, {29'b0, st});
    check({tag, ".w_retired"}, {29'b0, w_retired}, exp_ret & 32'h7);
    @(negedge clk);
  endtask

  function automatic logic [31:0] enc(input int k);
    logic [31:0] w;
    logic [5:0]  f;
    w = $urandom;
    case (k)
      K_ADD: begin w[31:26] = 6'b000000; w[5:0] = 6'b100000; end
      K_SUB: begin w[31:26] = 6'b000000; w[5:0] = 6'b100010; end
      K_JR:  begin w[31:26] = 6'b000000; w[5:0] = 6'b001000; end
      K_ORI: w[31:26] = 6'b001101;
      K_LUI: w[31:26] = 6'b001111;
      K_LW:  w[31:26] = 6'b100011;
      K_SW:  w[31:26] = 6'b101011;
      K_BEQ: w[31:26] = 6'b000100;
      K_JAL: w[31:26] = 6'b000011;
      K_BADOP: begin
        do f = 6'($urandom);
        while (f inside {6'b000000, 6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000011});
        w[31:26] = f;
      end
      default: begin
        w[31:26] = 6'b000000;
        do f = 6'($urandom);
        while (f inside {6'b100000, 6'b100010, 6'b001000});
        w[5:0] = f;
      end
    endcase
    return w;
  endfunction

  // Expected cycle trace of one instruction from its class; do_abort resets mid-MEM (needs dmw >= 2).
  task automatic run_instr(input logic [31:0] instr, input int k, input int imw, input int dmw,
                           input bit z, input bit do_abort);
    logic [15:0] mw;
    ir = $urandom;
    for (int i = 0; i < imw; i++) begin
      im_ready = 1'b0; dm_ready = 1'($urandom); alu_zero = 1'($urandom);
      step("fetch_wait", 3'd0, C_IMREQ);
    end
    im_ready = 1'b1; dm_ready = 1'($urandom);
    step("fetch", 3'd0, C_IMREQ | C_IRWE | C_PCWE);
    ir = instr; im_ready = 1'($urandom); dm_ready = 1'($urandom); alu_zero = 1'($urandom);
    if (k == K_JAL) begin
      step("dec_jal", 3'd1, C_AB | C_RFWE | wr(2'd2) | wd(2'd2) | C_PCWE | npc(2'd2));
    end else if (k == K_JR) begin
      step("dec_jr", 3'd1, C_AB | C_PCWE | npc(2'd3));
    end else if (k == K_BADOP || k == K_BADFN) begin
      step("dec_ill", 3'd1, C_AB | C_ILL);
    end else begin
      step("dec", 3'd1, C_AB);
      im_ready = 1'($urandom); dm_ready = 1'($urandom);
      if (k == K_BEQ) begin
        alu_zero = z;
        step("br", 3'd3, (z ? C_PCWE : C_NONE) | npc(2'd1));
      end else begin
        step("exe", 3'd2, C_ALU);
        if (k == K_LW || k == K_SW) begin
          mw = (k == K_SW) ? C_DMWE : C_NONE;
          for (int i = 0; i < dmw; i++) begin
            dm_ready = 1'b0; im_ready = 1'($urandom);
            if (do_abort && i == 1) begin
              reset = 1'b1;
              #2;
              check("abort.ctl",   {16'b0, ctl},   32'd0);
              check("abort.state", {29'b0, state}, 32'd0);
              @(negedge clk);
              exp_ret = 32'd0;
              check("abort.retired", retired, exp_ret);
              reset = 1'b0; im_ready = 1'b0;
              return;
            end
            step("mem_wait", 3'd4, C_DMREQ | mw);
          end
          dm_ready = 1'b1; im_ready = 1'($urandom);
          step("mem", 3'd4, C_DMREQ | mw | ((k == K_LW) ? C_MDR : C_NONE));
        end
        if (k != K_SW) begin
          dm_ready = 1'($urandom);
          step("wb", 3'd5, C_RFWE | ((k == K_ADD || k == K_SUB) ? wr(2'd1) : C_NONE)
                                  | ((k == K_LW) ? wd(2'd1) : C_NONE));
        end
      end
    end
    exp_ret = exp_ret + 32'd1;
  endtask

  initial begin
    int k;
    reset = 1'b1; im_ready = 1'b1; dm_ready = 1'b1; alu_zero = 1'b1; ir = 32'h00221820;
    @(negedge clk);
    step("reset_held", 3'd0, C_NONE);
    reset = 1'b0; im_ready = 1'b0;
    step("post_release", 3'd0, C_IMREQ);

    run_instr(32'h00221820, K_ADD, 0, 0, 1'b0, 1'b0);
    run_instr(32'h8C220004, K_LW, 0, 3, 1'b0, 1'b0);
    run_instr(32'h10220003, K_BEQ, 0, 0, 1'b1, 1'b0);
    run_instr(32'h10220003, K_BEQ, 1, 0, 1'b0, 1'b0);
    run_instr(32'h0C000010, K_JAL, 0, 0, 1'b0, 1'b0);
    run_instr(32'hFC000000, K_BADOP, 0, 0, 1'b0, 1'b0);
    run_instr(enc(K_JR), K_JR, 2, 0, 1'b0, 1'b0);
    run_instr(enc(K_SW), K_SW, 0, 1, 1'b0, 1'b0);
    run_instr(enc(K_SW), K_SW, 0, 3, 1'b0, 1'b1);
    step("abort_refetch", 3'd0, C_IMREQ);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 10);
      run_instr(enc(k), k, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'b0);
    end
    im_ready = 1'b0;
    step("final", 3'd0, C_IMREQ);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
